// File: rtl/operand_fetch_if.sv
// operand_fetch_if: instruction intake, register-file read port and operand bundle signals
interface operand_fetch_if;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] IR;
  logic [3:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pc_plus8;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_IR;
  logic [31:0] op_Rn;
  logic [31:0] op_Rm;
  logic [7:0]  op_shamt;
  logic        op_reg_shift;
  modport slave (
    input  ir_valid, IR, rf_data, pc_plus8, op_ready,
    output ir_ready, rf_addr, op_valid, op_IR, op_Rn, op_Rm, op_shamt, op_reg_shift
  );
  modport master (
    output ir_valid, IR, rf_data, pc_plus8, op_ready,
    input  ir_ready, rf_addr, op_valid, op_IR, op_Rn, op_Rm, op_shamt, op_reg_shift
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: decodes an instruction, reads Rn/Rm/Rs serially and issues an operand bundle
module operand_fetch (
  input logic clk,
  input logic reset,
  operand_fetch_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, RD_RN = 3'd1, RD_RM = 3'd2, RD_RS = 3'd3, ISSUE = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d, rn_q, rn_d, rm_q, rm_d;
  logic [7:0]  shamt_q, shamt_d;
  logic        reg_shift_q, reg_shift_d, op_valid_q, op_valid_d;
  logic        accept, done, new_rm, new_rs, cur_rm, cur_rs;
  logic [31:0] rd_val;
  assign new_rs = bus.IR[27:25] == 3'b000 && bus.IR[4] && !bus.IR[7];
  assign new_rm = bus.IR[27:25] == 3'b000 || bus.IR[27:25] == 3'b011;
  assign cur_rs = ir_q[27:25] == 3'b000 && ir_q[4] && !ir_q[7];
  assign cur_rm = ir_q[27:25] == 3'b000 || ir_q[27:25] == 3'b011;
  assign bus.ir_ready = state_q == IDLE || (state_q == ISSUE && bus.op_ready);
  assign accept = bus.ir_valid && bus.ir_ready;
  assign done = op_valid_q && bus.op_ready;
  assign bus.op_valid = op_valid_q;
  assign bus.op_IR = ir_q;
  assign bus.op_Rn = rn_q;
  assign bus.op_Rm = rm_q;
  assign bus.op_shamt = shamt_q;
  assign bus.op_reg_shift = reg_shift_q;
  // read address follows the current read state; R15 reads see the PC, plus 4 more for Rn/Rm of a register-shift form
  always_comb begin
    bus.rf_addr = state_q == RD_RN ? ir_q[19:16] :
                  state_q == RD_RM ? ir_q[3:0]   :
                  state_q == RD_RS ? ir_q[11:8]  : 4'd0;
    rd_val = bus.rf_addr == 4'd15 ? bus.pc_plus8 + {29'd0, cur_rs && state_q != RD_RS, 2'b00} : bus.rf_data;
  end
  // sequencing: accept a new word, step through the required reads, hold the bundle until consumed
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    rn_d = rn_q;
    rm_d = rm_q;
    shamt_d = shamt_q;
    reg_shift_d = reg_shift_q;
    if (accept) begin
      state_d = bus.IR[27] ? ISSUE : RD_RN;
      ir_d = bus.IR;
      rn_d = '0;
      rm_d = '0;
      shamt_d = new_rm && !new_rs ? {3'b000, bus.IR[11:7]} : 8'd0;
      reg_shift_d = new_rs;
    end else if (done) begin
      state_d = IDLE;
    end else if (state_q == RD_RN) begin
      rn_d = rd_val;
      state_d = cur_rm ? RD_RM : ISSUE;
    end else if (state_q == RD_RM) begin
      rm_d = rd_val;
      state_d = cur_rs ? RD_RS : ISSUE;
    end else if (state_q == RD_RS) begin
      shamt_d = rd_val[7:0];
      state_d = ISSUE;
    end
    op_valid_d = state_d == ISSUE;
  end
  // state and bundle registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q <= '0;
      rn_q <= '0;
      rm_q <= '0;
      shamt_q <= '0;
      reg_shift_q <= 1'b0;
      op_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      rn_q <= rn_d;
      rm_q <= rm_d;
      shamt_q <= shamt_d;
      reg_shift_q <= reg_shift_d;
      op_valid_q <= op_valid_d;
    end
  end
endmodule
